// File: rtl/irda_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | irda_pkg : shared IrDA SIR types, default timing and frame constants  |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package irda_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int IRDA_CLKS_PER_BIT = 1302;
   localparam int IRDA_PULSE_START  = 651;
   localparam int IRDA_PULSE_LEN    = 244;
   localparam int DATA_BITS         = 8;
   localparam int FRAME_BITS        = 10;

endpackage
`default_nettype wire

// File: rtl/irda_bit_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | irda_bit_timer : per-bit cycle counter, bit_end strobe, pulse window  |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module irda_bit_timer #(
   parameter int CLKS_PER_BIT = 1302,
   parameter int PULSE_START  = 651,
   parameter int PULSE_LEN    = 244,
   parameter int CNT_W        = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             bit_end,
   output logic             window_next
);

   logic [CNT_W-1:0] w_count_next;

   assign bit_end = enable && (count == CNT_W'(CLKS_PER_BIT - 1));

   always_comb begin
      w_count_next = count;
      if (clear) begin
         w_count_next = '0;
      end else if (enable) begin
         w_count_next = bit_end ? '0 : count + CNT_W'(1);
      end
   end

   // Window of the upcoming offset, so a registered consumer lines up with c
   assign window_next = (w_count_next >= CNT_W'(PULSE_START)) &&
                        (w_count_next <= CNT_W'(PULSE_START + PULSE_LEN - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else begin
         count <= w_count_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/irda_tx_framer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | irda_tx_framer : byte-to-IrDA SIR start/8-data/stop frame sequencer   |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module irda_tx_framer
   import irda_pkg::*;
#(
   parameter int CLKS_PER_BIT = IRDA_CLKS_PER_BIT,
   parameter int PULSE_START  = IRDA_PULSE_START,
   parameter int PULSE_LEN    = IRDA_PULSE_LEN,
   parameter int CNT_W        = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       ir_out,
   output logic       busy,
   output logic       frame_done
);

   localparam int IDX_W = $clog2(DATA_BITS);

   if ((PULSE_START + PULSE_LEN > CLKS_PER_BIT) || (CLKS_PER_BIT > 2**CNT_W)) begin : g_param_check
      $fatal(1, "irda_tx_framer: pulse window or counter width inconsistent with CLKS_PER_BIT");
   end

   tx_state_t        r_state, w_state_next;
   logic [7:0]       r_shift, w_shift_next;
   logic [IDX_W-1:0] r_bit_idx, w_bit_idx_next;
   logic             r_ir, w_ir_next;
   logic             w_accept, w_bit_end, w_window_next;
   logic [CNT_W-1:0] w_count;

   irda_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .PULSE_START  (PULSE_START),
      .PULSE_LEN    (PULSE_LEN),
      .CNT_W        (CNT_W)
   ) u_bit_timer (
      .clk         (clk),
      .reset       (reset),
      .clear       (w_accept),
      .enable      (r_state != IDLE),
      .count       (w_count),
      .bit_end     (w_bit_end),
      .window_next (w_window_next)
   );

   assign tx_ready   = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);
   assign w_accept   = tx_valid && tx_ready;
   assign busy       = (r_state != IDLE);
   assign frame_done = (r_state == STOP) && w_bit_end;
   assign ir_out     = r_ir;

   always_comb begin
      w_state_next   = r_state;
      w_shift_next   = r_shift;
      w_bit_idx_next = r_bit_idx;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_next   = START;
               w_shift_next   = tx_data;
               w_bit_idx_next = '0;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state_next   = DATA;
               w_bit_idx_next = '0;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
                  w_state_next = STOP;
               end else begin
                  w_shift_next   = r_shift >> 1;
                  w_bit_idx_next = r_bit_idx + IDX_W'(1);
               end
            end
         end
         STOP: begin
            if (w_bit_end) begin
               if (w_accept) begin
                  w_state_next   = START;
                  w_shift_next   = tx_data;
                  w_bit_idx_next = '0;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
      // Pulse only for 0 bits: the start bit, or a data bit whose LSB is clear
      w_ir_next = w_window_next &&
                  ((w_state_next == START) || ((w_state_next == DATA) && !w_shift_next[0]));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_ir      <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_shift   <= w_shift_next;
         r_bit_idx <= w_bit_idx_next;
         r_ir      <= w_ir_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_irda_tx_framer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_irda_tx_framer : frame-level model bench for irda_tx_framer        |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module tb_irda_tx_framer;

   localparam int CPB   = 1302;
   localparam int PS    = 651;
   localparam int PL    = 244;
   localparam int FRAME = 10 * CPB;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_ready, ir_out, busy, frame_done;

   irda_tx_framer dut (
      .clk        (clk),
      .reset      (reset),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .ir_out     (ir_out),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Frame model: one active frame described by its acceptance edge and byte
   int         cur_a = -1;
   logic [7:0] cur_byte = 8'h00;
   int         accepts[$];
   int         dones[$];
   int         rises[$];
   int         falls[$];
   logic       prev_ir = 1'b0;

   // Returns {ir_out, busy, frame_done, tx_ready} for the cycle ending at edge n
   function automatic logic [3:0] model_out(input int n);
      int   o, b, c;
      logic inf, bv, ir, dn;
      inf = (cur_a >= 0) && (n > cur_a) && (n <= cur_a + FRAME);
      ir  = 1'b0;
      dn  = 1'b0;
      if (inf) begin
         o  = n - cur_a - 1;
         b  = o / CPB;
         c  = o % CPB;
         bv = (b == 0) ? 1'b0 : (b <= 8) ? cur_byte[b-1] : 1'b1;
         ir = !bv && (c >= PS) && (c < PS + PL);
         dn = (n == cur_a + FRAME);
      end
      return {ir, inf, dn, (!inf || dn)};
   endfunction

   always @(negedge clk) begin
      int         n;
      logic [3:0] e;
      n = cyc + 1;
      if (reset) cur_a = -1;
      e = model_out(n);
      chk("outputs{ir,busy,done,ready}", int'({ir_out, busy, frame_done, tx_ready}), int'(e));
      if (ir_out && !prev_ir) rises.push_back(n);
      if (!ir_out && prev_ir) falls.push_back(n);
      prev_ir = ir_out;
      if (frame_done) dones.push_back(n);
      if (!reset && tx_valid && e[0]) begin
         cur_a    = n;
         cur_byte = tx_data;
         accepts.push_back(n);
      end
   end

   task automatic idle(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input int budget);
      int start;
      start    = accepts.size();
      tx_data  = b;
      tx_valid = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (accepts.size() > start) return;
      end
      chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_done(input int budget);
      int start;
      start = dones.size();
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (dones.size() > start) return;
      end
      chk("frame_done_timeout", 0, 1);
   endtask

   function automatic int count_rises(input int lo, input int hi);
      int k;
      k = 0;
      foreach (rises[i]) if (rises[i] >= lo && rises[i] <= hi) k++;
      return k;
   endfunction

   function automatic int first_rise(input int lo);
      foreach (rises[i]) if (rises[i] >= lo) return rises[i];
      return -1;
   endfunction

   initial begin
      int a, a_ff, a_00, a_a5, a_3c, rb, nd, r0;

      // Reset state
      idle(3);
      reset = 1'b0;
      #1;
      chk("reset_ir_out", int'(ir_out), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_frame_done", int'(frame_done), 0);
      chk("reset_tx_ready", int'(tx_ready), 1);

      // 0x55 from idle, with an ignored 0x12 poke mid-DATA
      rb = rises.size();
      send(8'h55, 10);
      a = accepts[$];
      tx_valid = 1'b0;
      idle(4000);
      tx_data  = 8'h12;
      tx_valid = 1'b1;
      #1;
      chk("ready_while_busy", int'(tx_ready), 0);
      idle(1);
      tx_valid = 1'b0;
      wait_done(20000);
      chk("poke_not_accepted", accepts.size(), 1);
      chk("55_pulse_count", rises.size() - rb, 5);
      chk("55_first_rise", rises[rb] - a, 652);
      chk("55_last_rise", rises[rb+4] - a, 11068);
      chk("55_pulse_width", falls[rb] - rises[rb], 244);
      chk("55_frame_done", dones[$] - a, 13020);
      idle(5);

      // Back-to-back stream: 0xFF, 0x00, 0xA5, 0x3C with tx_valid held
      send(8'hFF, 10);   a_ff = accepts[$];
      send(8'h00, 20000); a_00 = accepts[$];
      send(8'hA5, 20000); a_a5 = accepts[$];
      send(8'h3C, 20000); a_3c = accepts[$];
      tx_valid = 1'b0;
      wait_done(20000);
      chk("ff_to_00_gap", a_00 - a_ff, 13020);
      chk("ff_pulse_count", count_rises(a_ff + 1, a_ff + FRAME), 1);
      chk("00_pulse_count", count_rises(a_00 + 1, a_00 + FRAME), 9);
      r0 = first_rise(a_00 + 1);
      chk("00_pulse_spacing", first_rise(r0 + 1) - r0, 1302);
      chk("a5_pulse_count", count_rises(a_a5 + 1, a_a5 + FRAME), 5);
      chk("3c_pulse_count", count_rises(a_3c + 1, a_3c + FRAME), 5);
      chk("3c_accept_on_done", dones[dones.size()-2], a_3c);
      chk("3c_start_vs_a5_stop", first_rise(a_3c + 1) - (a_a5 + 1 + 9 * CPB), CPB + PS);
      idle(5);

      // Reset mid-frame, then a clean 0x81 frame
      send(8'hC3, 10);
      a = accepts[$];
      tx_valid = 1'b0;
      idle(4999);
      nd    = dones.size();
      reset = 1'b1;
      #1;
      chk("async_rst_ir_out", int'(ir_out), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_frame_done", int'(frame_done), 0);
      idle(3);
      reset = 1'b0;
      #1;
      chk("post_rst_tx_ready", int'(tx_ready), 1);
      chk("post_rst_busy", int'(busy), 0);
      rb = rises.size();
      send(8'h81, 10);
      a = accepts[$];
      tx_valid = 1'b0;
      wait_done(20000);
      chk("no_done_for_abandoned", dones.size() - nd, 1);
      chk("81_pulse_count", rises.size() - rb, 7);
      chk("81_first_rise", rises[rb] - a, 652);
      chk("81_frame_done", dones[$] - a, 13020);

      // Quiet line with no valid
      rb = rises.size();
      idle(4000);
      chk("idle_no_pulse", rises.size() - rb, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
